// File: rtl/c6_stream.sv
// C6 extraction unit: accepts a word over valid/ready, folds LANES bytes per beat,
// streams the per-beat results and assembles the packed C6 word.
module c6_stream #(
    parameter int NUM_BYTES = 8,
    parameter int LANES     = 1,
    localparam int BEATS    = NUM_BYTES / LANES,
    localparam int IDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NUM_BYTES-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6*LANES-1:0]       out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic [6*NUM_BYTES-1:0]   word_out,
    output logic                     word_valid
);

    localparam int BW = 6 * LANES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if (NUM_BYTES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_params
        $error("c6_stream: LANES must divide NUM_BYTES and NUM_BYTES must be >= 1");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [8*NUM_BYTES-1:0]   word_q, word_d;
    logic [6*NUM_BYTES-1:0]   pack_q, pack_d;
    logic [6*NUM_BYTES-1:0]   wout_q, wout_d;
    logic                     wvld_q, wvld_d;
    logic [BW-1:0]            beat_fold;

    function automatic logic [5:0] c6_fold(input logic [7:0] b);
        return {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
    endfunction

    always_comb begin
        beat_fold = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_fold[6*k +: 6] = c6_fold(word_q[(int'(idx_q) * LANES + k) * 8 +: 8]);
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        pack_d    = pack_q;
        wout_d    = wout_q;
        wvld_d    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_data  = beat_fold;
                out_last  = (idx_q == LAST_IDX);
                in_ready  = out_last && out_ready;
                if (out_ready) begin
                    pack_d[int'(idx_q) * BW +: BW] = beat_fold;
                    if (!out_last) begin
                        idx_d = idx_q + 1'b1;
                    end else begin
                        // final slot is merged here so word_out never lags a beat
                        wout_d = pack_d;
                        wvld_d = 1'b1;
                        idx_d  = '0;
                        if (in_valid) begin
                            word_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            pack_q  <= '0;
            wout_q  <= '0;
            wvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            pack_q  <= pack_d;
            wout_q  <= wout_d;
            wvld_q  <= wvld_d;
        end
    end

    assign out_idx    = idx_q;
    assign word_out   = wout_q;
    assign word_valid = wvld_q;

endmodule

// File: tb/tb_c6_stream.sv
// Bench for c6_stream: two instances (LANES=1 and LANES=4) checked every cycle
// against a queue-based word model, plus literal expectations from hand-folded bytes.
module tb_c6_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_word_valid;
    logic [63:0] a_in_data;
    logic [5:0]  a_out_data;
    logic [2:0]  a_out_idx;
    logic [47:0] a_word_out;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_word_valid;
    logic [63:0] b_in_data;
    logic [23:0] b_out_data;
    logic [0:0]  b_out_idx;
    logic [47:0] b_word_out;

    c6_stream #(.NUM_BYTES(8), .LANES(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last),
        .word_out(a_word_out), .word_valid(a_word_valid)
    );

    c6_stream #(.NUM_BYTES(8), .LANES(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last),
        .word_out(b_word_out), .word_valid(b_word_valid)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference fold of a whole 8-byte word, straight from the bit table.
    function automatic logic [47:0] c6_word(input logic [63:0] d);
        logic [47:0] w;
        logic [7:0]  b;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            b = d[8*i +: 8];
            w[6*i +: 6] = {b[7] ^ b[1], b[3], b[2], b[5] ^ b[0], b[4], b[6]};
        end
        return w;
    endfunction

    // Model: words accepted but not yet fully emitted, and beat count within the head word.
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int          cnt[2];
    logic [47:0] exp_wo[2];
    bit          exp_wv[2];
    bit          stl[2];
    logic [23:0] pdat[2];

    task automatic model_step(input int d, input int lanes, input logic iv, input logic ir,
                              input logic [63:0] idat, input logic ov, input logic ordy,
                              input logic [23:0] od, input int oidx, input logic olast,
                              input logic [47:0] wo, input logic wv);
        string       pre;
        int          beats;
        int          qsz;
        bit          busy;
        bit          exp_ir;
        logic [63:0] head;
        logic [47:0] e;
        logic [23:0] mask;
        pre   = (d == 0) ? "a_" : "b_";
        beats = 8 / lanes;
        mask  = (lanes == 1) ? 24'h3F : 24'hFFFFFF;
        if (!rst_n) begin
            chk({pre, "rst_out_valid"}, 64'(ov), 64'd0);
            chk({pre, "rst_in_ready"}, 64'(ir), 64'd1);
            chk({pre, "rst_word_out"}, 64'(wo), 64'd0);
            chk({pre, "rst_word_valid"}, 64'(wv), 64'd0);
            chk({pre, "rst_out_last"}, 64'(olast), 64'd0);
            chk({pre, "rst_out_data"}, 64'(od), 64'd0);
            if (d == 0) q0.delete(); else q1.delete();
            cnt[d] = 0; exp_wo[d] = '0; exp_wv[d] = 0; stl[d] = 0;
            return;
        end
        qsz    = (d == 0) ? q0.size() : q1.size();
        busy   = (qsz != 0);
        exp_ir = !busy || ((cnt[d] == beats - 1) && ordy);
        chk({pre, "out_valid"}, 64'(ov), 64'(busy));
        chk({pre, "in_ready"}, 64'(ir), 64'(exp_ir));
        chk({pre, "word_valid"}, 64'(wv), 64'(exp_wv[d]));
        chk({pre, "word_out"}, 64'(wo), 64'(exp_wo[d]));
        head = '0;
        if (busy) begin
            head = (d == 0) ? q0[0] : q1[0];
            e    = c6_word(head);
            chk({pre, "out_data"}, 64'(od), 64'((e >> (cnt[d] * 6 * lanes)) & 48'(mask)));
            chk({pre, "out_idx"}, 64'(oidx), 64'(cnt[d]));
            chk({pre, "out_last"}, 64'(olast), 64'(cnt[d] == beats - 1));
            if (stl[d]) chk({pre, "stall_hold"}, 64'(od), 64'(pdat[d]));
        end
        exp_wv[d] = 0;
        if (busy && ordy) begin
            if (cnt[d] == beats - 1) begin
                exp_wo[d] = c6_word(head);
                exp_wv[d] = 1;
                cnt[d]    = 0;
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end else begin
                cnt[d]++;
            end
        end
        if (iv && exp_ir) begin
            if (d == 0) q0.push_back(idat); else q1.push_back(idat);
        end
        stl[d]  = busy && !ordy;
        pdat[d] = od;
    endtask

    always @(negedge clk) begin
        model_step(0, 1, a_in_valid, a_in_ready, a_in_data, a_out_valid, a_out_ready,
                   24'(a_out_data), int'(a_out_idx), a_out_last, a_word_out, a_word_valid);
        model_step(1, 4, b_in_valid, b_in_ready, b_in_data, b_out_valid, b_out_ready,
                   b_out_data, int'(b_out_idx), b_out_last, b_word_out, b_word_valid);
    end

    // Directed word with literal expectations for the first beat and the packed word.
    task automatic send(input int d, input logic [63:0] data, input logic [47:0] ew,
                        input logic [23:0] eb0);
        bit ok;
        @(posedge clk); #1;
        if (d == 0) begin a_in_valid = 1; a_in_data = data; end
        else        begin b_in_valid = 1; b_in_data = data; end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((d == 0) ? a_in_ready : b_in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (d == 0) a_in_valid = 0; else b_in_valid = 0;
        @(negedge clk);
        chk("lit_beat0", (d == 0) ? 64'(a_out_data) : 64'(b_out_data), 64'(eb0));
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if ((d == 0) ? a_word_valid : b_word_valid) begin
                ok = 1;
                chk("lit_word_out", (d == 0) ? 64'(a_word_out) : 64'(b_word_out), 64'(ew));
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("word_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst_n = 0;
        a_in_valid = 0; a_in_data = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        send(0, 64'h00000000000000A5, 48'h000000000028, 24'h28);
        send(0, 64'hFFFFFFFFFFFFFFFF, 48'h6DB6DB6DB6DB, 24'h1B);
        send(0, 64'h0000000000408001, 48'h000000001804, 24'h04);
        send(1, 64'hFFFFFFFF000000A5, 48'h6DB6DB000028, 24'h000028);

        // Reset mid-word: accept a word, stall it, then pull reset.
        @(posedge clk); #1;
        a_in_valid = 1; a_in_data = 64'h0123456789ABCDEF; a_out_ready = 0;
        @(posedge clk); #1;
        a_in_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        chk("lit_rst_word_out", 64'(a_word_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1; a_out_ready = 1;

        // Two back-to-back words under backpressure, then random traffic.
        @(posedge clk); #1;
        a_in_valid = 1; a_in_data = {$urandom, $urandom};
        b_in_valid = 1; b_in_data = {$urandom, $urandom};
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if (a_in_valid && a_in_ready) a_in_data = {$urandom, $urandom};
            if (b_in_valid && b_in_ready) b_in_data = {$urandom, $urandom};
            if (c > 40) begin
                a_in_valid = ($urandom % 3) != 0;
                b_in_valid = ($urandom % 3) != 0;
            end
            a_out_ready = ($urandom % 3) != 0;
            b_out_ready = ($urandom % 2) != 0;
        end
        a_in_valid = 0; b_in_valid = 0;
        a_out_ready = 1; b_out_ready = 1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("drain_a_idle", 64'(a_out_valid), 64'd0);
        chk("drain_b_idle", 64'(b_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
